// File: rtl/fifo_rd_scheduler.sv
// Round-robin burst read scheduler: drains NUM_Q registered-dout FIFOs into one
// valid/ready stream through a 3-entry output buffer, tagging words with their queue ID.
module fifo_rd_scheduler #(
  parameter int WIDTH = 8,
  parameter int NUM_Q = 4,
  parameter int BURST = 4,
  parameter int QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                   clk,
  input  logic                   rst_sync,
  input  logic [NUM_Q-1:0]       q_empty,
  output logic [NUM_Q-1:0]       q_rd_en,
  input  logic [NUM_Q*WIDTH-1:0] q_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [QID_W-1:0]       m_qid
);

  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_reg, state_next;
  logic [QID_W-1:0]   gnt_reg, gnt_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         occ_reg, occ_next;
  logic               infl_reg;
  logic [QID_W-1:0]   infl_qid_reg;
  logic [WIDTH-1:0]   buf_data_reg [3];
  logic [WIDTH-1:0]   buf_data_next [3];
  logic [QID_W-1:0]   buf_qid_reg [3];
  logic [QID_W-1:0]   buf_qid_next [3];

  logic [WIDTH-1:0]   dout_arr [NUM_Q];
  logic               credit;
  logic               pick_found;
  logic [QID_W-1:0]   pick_qid;
  logic               pop;
  logic [QID_W-1:0]   pop_qid;
  logic               deq;
  logic [1:0]         wpos;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_Q; gi++) begin : g_q
      assign dout_arr[gi] = q_dout[gi*WIDTH +: WIDTH];
      assign q_rd_en[gi]  = pop && (pop_qid == QID_W'(gi)) && !rst_sync;
    end
  endgenerate

  // Credit counts the word already in flight so the buffer can never overflow.
  assign credit = (3'(occ_reg) + 3'(infl_reg)) < 3'd3;
  assign deq    = (occ_reg != 2'd0) && m_ready;

  // Rotating search: gnt+1 first, gnt itself last; descending loop lets the nearest win.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_qid   = '0;
    idx        = 0;
    for (int k = NUM_Q; k >= 1; k--) begin
      idx = (int'(gnt_reg) + k) % NUM_Q;
      if (!q_empty[idx]) begin
        pick_found = 1'b1;
        pick_qid   = QID_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    pop_qid    = gnt_reg;
    if (credit) begin
      if (state_reg == ACTIVE && !q_empty[gnt_reg] && cnt_reg < CNT_W'(BURST)) begin
        pop      = 1'b1;
        cnt_next = cnt_reg + 1'b1;
      end else if (pick_found) begin
        pop        = 1'b1;
        pop_qid    = pick_qid;
        gnt_next   = pick_qid;
        cnt_next   = CNT_W'(1);
        state_next = ACTIVE;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Head-at-index-0 shift buffer; the captured word lands behind any survivors.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      buf_data_next[i] = buf_data_reg[i];
      buf_qid_next[i]  = buf_qid_reg[i];
    end
    if (deq) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_next[i] = buf_data_reg[i+1];
        buf_qid_next[i]  = buf_qid_reg[i+1];
      end
    end
    wpos = occ_reg - {1'b0, deq};
    if (infl_reg) begin
      buf_data_next[wpos] = dout_arr[infl_qid_reg];
      buf_qid_next[wpos]  = infl_qid_reg;
    end
    occ_next = occ_reg + {1'b0, infl_reg} - {1'b0, deq};
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_reg    <= IDLE;
      gnt_reg      <= QID_W'(NUM_Q - 1);
      cnt_reg      <= '0;
      occ_reg      <= '0;
      infl_reg     <= 1'b0;
      infl_qid_reg <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_data_reg[i] <= '0;
        buf_qid_reg[i]  <= '0;
      end
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
      occ_reg   <= occ_next;
      infl_reg  <= pop;
      if (pop) begin
        infl_qid_reg <= pop_qid;
      end
      for (int i = 0; i < 3; i++) begin
        buf_data_reg[i] <= buf_data_next[i];
        buf_qid_reg[i]  <= buf_qid_next[i];
      end
    end
  end

  assign m_valid = (occ_reg != 2'd0);
  assign m_data  = buf_data_reg[0];
  assign m_qid   = buf_qid_reg[0];

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Bench for fifo_rd_scheduler: behavioural FIFO bank plus a word-level round-robin
// burst model that predicts the delivered stream.
module tb_fifo_rd_scheduler;

  localparam int WIDTH = 8;
  localparam int NUM_Q = 4;
  localparam int BURST = 4;
  localparam int QID_W = 2;
  localparam int DEPTH = 32;

  logic                   clk = 1'b0;
  logic                   rst_sync = 1'b1;
  logic [NUM_Q-1:0]       q_empty;
  logic [NUM_Q-1:0]       q_rd_en;
  logic [NUM_Q*WIDTH-1:0] q_dout;
  logic                   m_valid;
  logic                   m_ready = 1'b0;
  logic [WIDTH-1:0]       m_data;
  logic [QID_W-1:0]       m_qid;

  fifo_rd_scheduler #(.WIDTH(WIDTH), .NUM_Q(NUM_Q), .BURST(BURST), .QID_W(QID_W)) dut (
    .clk(clk), .rst_sync(rst_sync), .q_empty(q_empty), .q_rd_en(q_rd_en), .q_dout(q_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_qid(m_qid)
  );

  always #5 clk = ~clk;

  // FIFO bank with registered read data
  logic [WIDTH-1:0] mem [NUM_Q][DEPTH];
  logic [WIDTH-1:0] dout_reg [NUM_Q];
  int               wr_ptr [NUM_Q];
  int               rd_ptr [NUM_Q];
  logic             fifo_clr = 1'b1;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_Q; i++) begin
      if (fifo_clr) rd_ptr[i] <= 0;
      else if (q_rd_en[i] && rd_ptr[i] != wr_ptr[i]) begin
        dout_reg[i] <= mem[i][rd_ptr[i]];
        rd_ptr[i]   <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    q_empty = '0;
    q_dout  = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      q_empty[i] = (rd_ptr[i] == wr_ptr[i]);
      q_dout[i*WIDTH +: WIDTH] = dout_reg[i];
    end
  end

  // Protocol monitor: pop legality and output hold under backpressure
  int               proto_errs = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [QID_W-1:0] prev_qid = '0;

  always @(negedge clk) begin
    if (!rst_sync) begin
      if ((q_rd_en & q_empty) != '0 || $countones(q_rd_en) > 1) begin
        proto_errs <= proto_errs + 1;
        $display("protocol violation: rd_en=%b empty=%b", q_rd_en, q_empty);
      end
      if (prev_stall && (!m_valid || m_data != prev_data || m_qid != prev_qid)) begin
        proto_errs <= proto_errs + 1;
        $display("protocol violation: output changed while stalled");
      end
    end
    prev_stall <= !rst_sync && m_valid && !m_ready;
    prev_data  <= m_data;
    prev_qid   <= m_qid;
  end

  int checks = 0;
  int failures = 0;

  int               tr_vld[$], tr_rdy[$], tr_pop[$], tr_qid[$];
  logic [WIDTH-1:0] tr_data[$];
  int               exp_qid[$];
  logic [WIDTH-1:0] exp_data[$];
  int               acc_qid[$];
  logic [WIDTH-1:0] acc_data[$];

  task automatic do_reset();
    rst_sync = 1'b1;
    fifo_clr = 1'b1;
    m_ready  = 1'b0;
    for (int i = 0; i < NUM_Q; i++) wr_ptr[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_sync = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic load(input int q, input logic [WIDTH-1:0] d);
    mem[q][wr_ptr[q]] = d;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  // Runs n cycles, m_ready high with probability rdy_pct%, tracing every cycle
  task automatic run_cycles(input int n, input int rdy_pct);
    int p;
    tr_vld.delete(); tr_rdy.delete(); tr_pop.delete(); tr_qid.delete(); tr_data.delete();
    for (int c = 0; c < n; c++) begin
      m_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      p = -1;
      for (int i = 0; i < NUM_Q; i++) if (q_rd_en[i]) p = i;
      tr_pop.push_back(p);
      tr_vld.push_back(int'(m_valid));
      tr_rdy.push_back(int'(m_ready));
      tr_data.push_back(m_data);
      tr_qid.push_back(int'(m_qid));
      if (m_valid && m_ready) $display("xfer qid=%0d data=%02h", m_qid, m_data);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic collect_accepted();
    acc_qid.delete(); acc_data.delete();
    for (int c = 0; c < tr_vld.size(); c++) begin
      if (tr_vld[c] != 0 && tr_rdy[c] != 0) begin
        acc_qid.push_back(tr_qid[c]);
        acc_data.push_back(tr_data[c]);
      end
    end
  endtask

  // Word-level arbitration: keep the granted queue while it has words and the burst
  // is not used up, otherwise hand over to the next non-empty queue after it.
  function automatic void build_expected(input int lens[NUM_Q]);
    int rem[NUM_Q];
    int pos[NUM_Q];
    int g, run, total, cand;
    exp_qid.delete(); exp_data.delete();
    total = 0;
    for (int i = 0; i < NUM_Q; i++) begin
      rem[i] = lens[i]; pos[i] = 0; total += lens[i];
    end
    g = NUM_Q - 1;
    run = 0;
    while (total > 0) begin
      if (!(run > 0 && run < BURST && rem[g] > 0)) begin
        for (int k = 1; k <= NUM_Q; k++) begin
          cand = (g + k) % NUM_Q;
          if (rem[cand] > 0) begin
            g = cand;
            break;
          end
        end
        run = 0;
      end
      exp_qid.push_back(g);
      exp_data.push_back(mem[g][pos[g]]);
      pos[g]++; rem[g]--; run++; total--;
    end
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_qid !== '0 || q_rd_en !== '0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b data=%h qid=%0d rd_en=%b, want all zero", m_valid, m_data, m_qid, q_rd_en);
    end
    load(3, 8'h5A);
    run_cycles(3, 0);
    rst_sync = 1'b1;
    load(0, 8'h11);
    load(2, 8'h22);
    @(posedge clk);
    #1;
    checks++;
    if (q_rd_en !== '0 || m_valid !== 1'b0 || m_data !== '0 || m_qid !== '0) begin
      failures++;
      $display("FAIL reset_values: rd_en=%b valid=%b data=%h qid=%0d, want all zero", q_rd_en, m_valid, m_data, m_qid);
    end
    rst_sync = 1'b0;
    #1;
    checks++;
    if (q_rd_en !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: rd_en=%b, want 0001", q_rd_en);
    end
    run_cycles(8, 100);
    collect_accepted();
    checks++;
    if (acc_qid.size() != 2 || acc_qid[0] != 0 || acc_qid[1] != 2 ||
        acc_data[0] !== 8'h11 || acc_data[1] !== 8'h22) begin
      failures++;
      $display("FAIL reset_drain: got %0d words, want q0=11 then q2=22", acc_qid.size());
    end
  endtask

  task automatic test_single_queue();
    logic [WIDTH-1:0] w;
    do_reset();
    load(1, 8'hA1); load(1, 8'hA2); load(1, 8'hA3);
    run_cycles(8, 100);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (tr_pop[c] != ((c < 3) ? 1 : -1)) begin
        failures++;
        $display("FAIL single_pop c%0d: pop=%0d, want %0d", c, tr_pop[c], (c < 3) ? 1 : -1);
      end
      checks++;
      w = 8'hA1 + 8'(c - 2);
      if ((c >= 2 && c <= 4) ? (tr_vld[c] != 1 || tr_data[c] !== w || tr_qid[c] != 1) : (tr_vld[c] != 0)) begin
        failures++;
        $display("FAIL single_out c%0d: valid=%0d data=%h qid=%0d, want valid=%0d data=%h qid=1",
                 c, tr_vld[c], tr_data[c], tr_qid[c], (c >= 2 && c <= 4) ? 1 : 0, w);
      end
    end
  endtask

  task automatic test_fair_bursts();
    do_reset();
    for (int q = 0; q < NUM_Q; q++)
      for (int k = 0; k < 6; k++) load(q, 8'($urandom));
    build_expected(wr_ptr);
    run_cycles(28, 100);
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (tr_pop[c] != exp_qid[c]) begin
        failures++;
        $display("FAIL fair_pop c%0d: pop=%0d, want %0d", c, tr_pop[c], exp_qid[c]);
      end
      checks++;
      if (tr_vld[c+2] != 1 || tr_data[c+2] !== exp_data[c] || tr_qid[c+2] != exp_qid[c]) begin
        failures++;
        $display("FAIL fair_out c%0d: valid=%0d data=%h qid=%0d, want 1 %h %0d",
                 c + 2, tr_vld[c+2], tr_data[c+2], tr_qid[c+2], exp_data[c], exp_qid[c]);
      end
    end
    checks++;
    if (tr_vld[26] != 0) begin
      failures++;
      $display("FAIL fair_end: valid=%0d after 24 words, want 0", tr_vld[26]);
    end
  endtask

  task automatic test_early_empty();
    do_reset();
    for (int k = 0; k < 2; k++) load(2, 8'($urandom));
    for (int k = 0; k < 5; k++) load(3, 8'($urandom));
    build_expected(wr_ptr);
    run_cycles(12, 100);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (tr_pop[c] != exp_qid[c] || tr_vld[c+2] != 1 || tr_qid[c+2] != exp_qid[c] ||
          tr_data[c+2] !== exp_data[c]) begin
        failures++;
        $display("FAIL early_empty c%0d: pop=%0d valid=%0d qid=%0d data=%h, want pop/qid %0d data %h",
                 c, tr_pop[c], tr_vld[c+2], tr_qid[c+2], tr_data[c+2], exp_qid[c], exp_data[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 10; k++) load(0, 8'($urandom));
    build_expected(wr_ptr);
    run_cycles(8, 0);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (tr_pop[c] != ((c < 3) ? 0 : -1)) begin
        failures++;
        $display("FAIL bp_pop c%0d: pop=%0d, want %0d", c, tr_pop[c], (c < 3) ? 0 : -1);
      end
      if (c >= 2) begin
        checks++;
        if (tr_vld[c] != 1 || tr_data[c] !== exp_data[0]) begin
          failures++;
          $display("FAIL bp_hold c%0d: valid=%0d data=%h, want 1 %h", c, tr_vld[c], tr_data[c], exp_data[0]);
        end
      end
    end
    run_cycles(20, 100);
    collect_accepted();
    checks++;
    if (acc_data.size() != 10) begin
      failures++;
      $display("FAIL bp_count: got %0d words, want 10", acc_data.size());
    end
    for (int j = 0; j < acc_data.size() && j < 10; j++) begin
      checks++;
      if (acc_data[j] !== exp_data[j] || acc_qid[j] != 0) begin
        failures++;
        $display("FAIL bp_word %0d: data=%h qid=%0d, want %h 0", j, acc_data[j], acc_qid[j], exp_data[j]);
      end
    end
  endtask

  task automatic test_random();
    int lens[NUM_Q];
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int q = 0; q < NUM_Q; q++) begin
        lens[q] = $urandom_range(12);
        for (int k = 0; k < lens[q]; k++) load(q, 8'($urandom));
      end
      build_expected(wr_ptr);
      run_cycles(250, 40 + 20 * r);
      collect_accepted();
      checks++;
      if (acc_data.size() != exp_data.size()) begin
        failures++;
        $display("FAIL rand%0d_count: got %0d words, want %0d", r, acc_data.size(), exp_data.size());
      end
      for (int j = 0; j < acc_data.size() && j < exp_data.size(); j++) begin
        checks++;
        if (acc_data[j] !== exp_data[j] || acc_qid[j] != exp_qid[j]) begin
          failures++;
          $display("FAIL rand%0d_word %0d: data=%h qid=%0d, want %h %0d",
                   r, j, acc_data[j], acc_qid[j], exp_data[j], exp_qid[j]);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int k = 0; k < 6; k++) load(1, 8'($urandom));
    run_cycles(3, 0);
    checks++;
    if (tr_vld[2] != 1 || tr_pop[2] != 1) begin
      failures++;
      $display("FAIL midrst_pre: valid=%0d pop=%0d before reset, want 1 1", tr_vld[2], tr_pop[2]);
    end
    rst_sync = 1'b1;
    fifo_clr = 1'b1;
    m_ready  = 1'b1;
    for (int i = 0; i < NUM_Q; i++) wr_ptr[i] = 0;
    @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || q_rd_en !== '0) begin
      failures++;
      $display("FAIL midrst_flush: valid=%b rd_en=%b, want 0 0", m_valid, q_rd_en);
    end
    rst_sync = 1'b0;
    fifo_clr = 1'b0;
    load(2, 8'h33);
    load(0, 8'h44);
    #1;
    checks++;
    if (q_rd_en !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_restart: rd_en=%b, want 0001", q_rd_en);
    end
    run_cycles(8, 100);
    collect_accepted();
    checks++;
    if (acc_qid.size() != 2 || acc_qid[0] != 0 || acc_data[0] !== 8'h44 ||
        acc_qid[1] != 2 || acc_data[1] !== 8'h33) begin
      failures++;
      $display("FAIL midrst_drain: got %0d words, want q0=44 then q2=33", acc_qid.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_queue();
    test_fair_bursts();
    test_early_empty();
    test_backpressure();
    test_random();
    test_midstream_reset();
    checks++;
    if (proto_errs != 0) begin
      failures++;
      $display("FAIL protocol: violations=%0d, want 0", proto_errs);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
